// File: rtl/alu_deco_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_deco_seq
// Purpose  : Registered ALU-control decoder with a valid/ready handshake on
//            both sides. Single-cycle ops are presented one cycle after they
//            are accepted. When the M extension is built in, mul/div/rem ops
//            also spend MD_CYCLES iteration cycles (busy=1) before they are
//            presented.
// Config   : ALU_DECO_MEXT_EN - when defined, builds M-extension decode, the
//            ITER state, the iteration counter and the busy/mulDiv outputs.
//            When undefined, f7=0000001 R-type decodes to 7 (single cycle),
//            and mulDiv/busy are tied to 0.
// Ports    : clk        - clock, rising edge
//            rstN       - asynchronous active-low reset
//            op         - opcode (carried, not yet used by decode)
//            f7, f3     - funct7 / funct3
//            aluOp      - instruction class from the control unit
//            inValid    - request valid;  inReady  - request can be accepted
//            aluControl - registered ALU code (CTRL_W bits, zero-extended)
//            mulDiv     - held result is an M-extension op
//            outValid   - aluControl valid; outReady - consumer accepts
//            busy       - multi-cycle op in progress
// Revision : 1.0 - initial release
// ============================================================================
module alu_deco_seq #(
    parameter int CTRL_W    = 4,
    parameter int MD_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [6:0]        op,
    input  logic [6:0]        f7,
    input  logic [2:0]        f3,
    input  logic [1:0]        aluOp,
    input  logic              inValid,
    output logic              inReady,
    output logic [CTRL_W-1:0] aluControl,
    output logic              mulDiv,
    output logic              outValid,
    input  logic              outReady,
    output logic              busy
);

    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // Elaboration-time guard on the parameter ranges.
    if (CTRL_W < 4 || MD_CYCLES < 2) begin : g_param_check
        $error("alu_deco_seq: CTRL_W must be >= 4 and MD_CYCLES >= 2");
    end

    // op is carried for future opcode qualification; it has no effect yet.
    logic op_unused;
    assign op_unused = ^op;

    // ------------------------------------------------------------------
    // Combinational decode of the request currently on the inputs
    // ------------------------------------------------------------------
    logic [3:0] base_code;   // shared R/I-type table for f3 != 000
    logic [3:0] dec_code;
`ifdef ALU_DECO_MEXT_EN
    logic       dec_md;
`endif

    always_comb begin
        base_code = 4'd7;
        case (f3)
            3'b000:  base_code = 4'd0;
            3'b001:  base_code = 4'd6;
            3'b010:  base_code = 4'd5;
            3'b011:  base_code = 4'd10;
            3'b100:  base_code = 4'd4;
            3'b101:  base_code = (f7 == F7_ALT) ? 4'd9 : 4'd8;
            3'b110:  base_code = 4'd3;
            3'b111:  base_code = 4'd2;
            default: base_code = 4'd7;
        endcase
    end

    always_comb begin
        dec_code = 4'd7;
`ifdef ALU_DECO_MEXT_EN
        dec_md   = 1'b0;
`endif
        case (aluOp)
            2'b00: dec_code = 4'd0;
            2'b01: dec_code = 4'd1;
            2'b10: begin
                if (f7 == F7_MEXT) begin
`ifdef ALU_DECO_MEXT_EN
                    dec_md = 1'b1;
                    case (f3[2:1])
                        2'b10:   dec_code = 4'd13;
                        2'b11:   dec_code = 4'd14;
                        default: dec_code = 4'd12;
                    endcase
`else
                    dec_code = 4'd7;
`endif
                end else if (f3 == 3'b000) begin
                    dec_code = (f7 == F7_ALT) ? 4'd1 : 4'd0;
                end else begin
                    dec_code = base_code;
                end
            end
            2'b11: dec_code = base_code;   // f3=000 -> add regardless of f7
            default: dec_code = 4'd7;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1
`ifdef ALU_DECO_MEXT_EN
        ,
        ITER = 2'd2
`endif
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t start_state;    // where an accepted request goes
    logic   accept;

`ifdef ALU_DECO_MEXT_EN
    localparam int                CNT_W    = $clog2(MD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);
    logic [CNT_W-1:0] cnt;

    assign start_state = dec_md ? ITER : HOLD;
`else
    assign start_state = HOLD;
`endif

    assign accept = inValid & inReady;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            aluControl <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                aluControl <= CTRL_W'(dec_code);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        case (state)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) begin
                    state_nxt = start_state;
                end
            end
`ifdef ALU_DECO_MEXT_EN
            ITER: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                end
            end
`endif
            HOLD: begin
                outValid = 1'b1;
                // Retiring and accepting on the same edge gives 1/cycle
                // throughput for back-to-back single-cycle ops.
                if (outReady) begin
                    inReady   = 1'b1;
                    state_nxt = inValid ? start_state : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // M-extension iteration counter and flags
    // ------------------------------------------------------------------
`ifdef ALU_DECO_MEXT_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt    <= '0;
            mulDiv <= 1'b0;
        end else begin
            if (accept) begin
                mulDiv <= dec_md;
            end
            if (accept && dec_md) begin
                cnt <= CNT_LOAD;
            end else if (state == ITER && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign busy = (state == ITER);
`else
    assign mulDiv = 1'b0;
    assign busy   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_deco_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_deco_seq
// Purpose  : Self-checking bench for alu_deco_seq. A transaction-level model
//            (pending result, remaining iteration cycles, held code) predicts
//            every output each cycle; directed sequences pin the corner
//            cases, then randomized traffic with occasional resets runs.
//            Honours ALU_DECO_MEXT_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_deco_seq;

    localparam int CTRL_W    = 5;
    localparam int MD_CYCLES = 4;
    localparam int BASE_TAB [8] = '{0, 6, 5, 10, 4, 8, 3, 2};

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic [6:0]        op = '0;
    logic [6:0]        f7 = '0;
    logic [2:0]        f3 = '0;
    logic [1:0]        aluOp = '0;
    logic              inValid = 1'b0;
    logic              inReady;
    logic [CTRL_W-1:0] aluControl;
    logic              mulDiv;
    logic              outValid;
    logic              outReady = 1'b0;
    logic              busy;

    int n_checks = 0;
    int n_err    = 0;

    alu_deco_seq #(.CTRL_W(CTRL_W), .MD_CYCLES(MD_CYCLES)) dut (
        .clk(clk), .rstN(rstN), .op(op), .f7(f7), .f3(f3), .aluOp(aluOp),
        .inValid(inValid), .inReady(inReady), .aluControl(aluControl),
        .mulDiv(mulDiv), .outValid(outValid), .outReady(outReady), .busy(busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference decode straight from the decode rules
    // ------------------------------------------------------------------
    function automatic int ref_code(input logic [1:0] a, input logic [6:0] f7v,
                                    input logic [2:0] f3v);
        bit alt;
        alt = (f7v == 7'h20);
        if (a == 2'd0) return 0;
        if (a == 2'd1) return 1;
        if (a == 2'd2 && f7v == 7'h01) begin
`ifdef ALU_DECO_MEXT_EN
            if (f3v < 3'd4) return 12;
            if (f3v < 3'd6) return 13;
            return 14;
`else
            return 7;
`endif
        end
        if (f3v == 3'd5) return alt ? 9 : 8;
        if (f3v == 3'd0) return (a == 2'd2 && alt) ? 1 : 0;
        return BASE_TAB[f3v];
    endfunction

    function automatic bit ref_md(input logic [1:0] a, input logic [6:0] f7v);
`ifdef ALU_DECO_MEXT_EN
        return (a == 2'd2 && f7v == 7'h01);
`else
        return (a == 2'd3 && a == 2'd2 && f7v == 7'h01);  // never an M op
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------
    bit m_pending;     // a result exists (computing or presented)
    int m_wait;        // iteration cycles still to go before presenting
    int m_code;
    bit m_md;
    bit m_accept;

    assign m_accept = inValid && (!m_pending || (m_wait == 0 && outReady));

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_pending <= 1'b0;
            m_wait    <= 0;
            m_code    <= 0;
            m_md      <= 1'b0;
        end else if (m_accept) begin
            m_pending <= 1'b1;
            m_code    <= ref_code(aluOp, f7, f3);
            m_md      <= ref_md(aluOp, f7);
            m_wait    <= ref_md(aluOp, f7) ? MD_CYCLES : 0;
        end else if (m_pending && m_wait > 0) begin
            m_wait <= m_wait - 1;
        end else if (m_pending && outReady) begin
            m_pending <= 1'b0;
        end
    end

    // Compare process: every output, every cycle, away from the edge.
    always @(negedge clk) begin
        check("inReady",    int'(inReady),    int'(!m_pending || (m_wait == 0 && outReady)));
        check("outValid",   int'(outValid),   int'(m_pending && m_wait == 0));
        check("busy",       int'(busy),       int'(m_wait > 0));
        check("mulDiv",     int'(mulDiv),     int'(m_md));
        check("aluControl", int'(aluControl), m_code);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [1:0] a, input logic [6:0] f7v, input logic [2:0] f3v);
        aluOp   = a;
        f7      = f7v;
        f3      = f3v;
        op      = 7'(($urandom));
        inValid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Pin the reference decode against hand-derived values.
        check("pin_r_sub",  ref_code(2'd2, 7'h20, 3'd0), 1);
        check("pin_i_add",  ref_code(2'd3, 7'h20, 3'd0), 0);
        check("pin_i_sra",  ref_code(2'd3, 7'h20, 3'd5), 9);
        check("pin_r_sltu", ref_code(2'd2, 7'h00, 3'd3), 10);
        check("pin_r_srl",  ref_code(2'd2, 7'h00, 3'd5), 8);
`ifdef ALU_DECO_MEXT_EN
        check("pin_m_div",  ref_code(2'd2, 7'h01, 3'd4), 13);
`else
        check("pin_m_off",  ref_code(2'd2, 7'h01, 3'd4), 7);
`endif

        // Reset state
        tick(); tick();
        check("rst_aluControl", int'(aluControl), 0);
        check("rst_outValid",   int'(outValid),   0);
        check("rst_busy",       int'(busy),       0);
        check("rst_mulDiv",     int'(mulDiv),     0);
        rstN = 1'b1;
        tick();
        check("rst_inReady", int'(inReady), 1);

        // R-type sub, latency 1
        outReady = 1'b1;
        req(2'd2, 7'h20, 3'd0);
        tick(); inValid = 1'b0; #1;
        check("sub_code",     int'(aluControl), 1);
        check("sub_outValid", int'(outValid),   1);
        check("sub_mulDiv",   int'(mulDiv),     0);

        // I-type back-to-back
        req(2'd3, 7'h20, 3'd0);
        tick(); #1;
        check("itype_add", int'(aluControl), 0);
        req(2'd3, 7'h20, 3'd5);
        tick(); #1;
        check("itype_sra", int'(aluControl), 9);
        inValid = 1'b0;
        tick();

        // Held output while the consumer stalls and inputs toggle
        outReady = 1'b0;
        req(2'd2, 7'h00, 3'd6);
        tick(); #1;
        check("hold_or", int'(aluControl), 3);
        for (int i = 0; i < 3; i++) begin
            req(2'($urandom), 7'($urandom), 3'($urandom));
            tick(); #1;
            check("hold_code",     int'(aluControl), 3);
            check("hold_inReady",  int'(inReady),    0);
            check("hold_outValid", int'(outValid),   1);
        end
        outReady = 1'b1;
        req(2'd2, 7'h00, 3'd4);
        #1;
        check("hold_release_ready", int'(inReady), 1);
        tick(); #1;
        check("hold_next_xor", int'(aluControl), 4);
        inValid = 1'b0;
        tick();

`ifdef ALU_DECO_MEXT_EN
        // Divide: busy for MD_CYCLES cycles, then presented
        req(2'd2, 7'h01, 3'd4);
        tick(); inValid = 1'b0;
        for (int i = 0; i < MD_CYCLES; i++) begin
            #1;
            check("div_busy",     int'(busy),     1);
            check("div_inReady",  int'(inReady),  0);
            check("div_outValid", int'(outValid), 0);
            tick();
        end
        #1;
        check("div_outValid_end", int'(outValid),   1);
        check("div_code",         int'(aluControl), 13);
        check("div_mulDiv",       int'(mulDiv),     1);
        check("div_busy_end",     int'(busy),       0);
        tick();

        // Reset in the middle of an iteration
        req(2'd2, 7'h01, 3'd6);
        tick(); inValid = 1'b0;
        tick();
        rstN = 1'b0; #1;
        check("abort_code",     int'(aluControl), 0);
        check("abort_busy",     int'(busy),       0);
        check("abort_outValid", int'(outValid),   0);
        check("abort_mulDiv",   int'(mulDiv),     0);
        tick(); rstN = 1'b1;
        tick(); #1;
        check("abort_no_retire", int'(outValid), 0);
        req(2'd2, 7'h00, 3'd7);
        tick(); inValid = 1'b0; #1;
        check("after_abort_and", int'(aluControl), 2);
        tick();
`else
        // M encoding without the extension: plain single-cycle code 7
        req(2'd2, 7'h01, 3'd0);
        tick(); inValid = 1'b0; #1;
        check("nomext_code",     int'(aluControl), 7);
        check("nomext_busy",     int'(busy),       0);
        check("nomext_mulDiv",   int'(mulDiv),     0);
        check("nomext_outValid", int'(outValid),   1);
        tick();

        // Reset while holding a result
        outReady = 1'b0;
        req(2'd2, 7'h00, 3'd1);
        tick(); inValid = 1'b0;
        rstN = 1'b0; #1;
        check("abort_outValid", int'(outValid),   0);
        check("abort_code",     int'(aluControl), 0);
        tick(); rstN = 1'b1; outReady = 1'b1;
        tick();
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] rf7;
            case ($urandom_range(0, 3))
                0:       rf7 = 7'h00;
                1:       rf7 = 7'h20;
                2:       rf7 = 7'h01;
                default: rf7 = 7'($urandom);
            endcase
            aluOp    = 2'($urandom);
            f3       = 3'($urandom);
            f7       = rf7;
            op       = 7'($urandom);
            inValid  = ($urandom_range(0, 2) != 0);
            outReady = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                rstN = 1'b0;
                tick();
                rstN = 1'b1;
            end else begin
                tick();
            end
        end

        inValid = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
